tristate_bus_arbiter: RTL

- Round-robin arbiter for a shared tri-state bus.
- N requesters each drive the bus through a bufif1-style driver. This block generates the one-hot driver enables, so at most one driver is ever enabled.
- A dead turnaround cycle is inserted between owners so no two drivers ever overlap.
- A hold limit stops one requester from monopolising the bus while others wait.

---
 rtl/tristate_bus_arbiter_if.sv | 32 +++
 rtl/tristate_bus_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/tristate_bus_arbiter_if.sv
// Handshake bundle between the round-robin bus arbiter and its requesters.
// The arbiter side uses the master modport; requester logic uses slave.
interface tristate_bus_arbiter_if #(
    parameter int N = 4
) ();
    localparam int ID_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    req;
    logic [N-1:0]    grant;
    logic [N-1:0]    bus_en;
    logic            bus_busy;
    logic [ID_W-1:0] owner_id;
    logic            turn;

    modport master (
        input  req,
        output grant,
        output bus_en,
        output bus_busy,
        output owner_id,
        output turn
    );

    modport slave (
        output req,
        input  grant,
        input  bus_en,
        input  bus_busy,
        input  owner_id,
        input  turn
    );
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter for a shared tri-state bus: one-hot registered driver
// enables, a dead turnaround cycle between owners and a contended hold limit.
module tristate_bus_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    tristate_bus_arbiter_if.master        bus
);
    localparam int ID_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [N-1:0]    bus_en_q;
    logic            busy_q;
    logic [ID_W-1:0] owner_q, owner_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [3:0]      hold_q, hold_d;
    logic            turn_q, turn_d;

    logic            any_req;
    logic            other_req;
    logic            owner_req;
    logic            hold_limit;
    logic [ID_W-1:0] winner;

    function automatic logic [N-1:0] onehot(input logic [ID_W-1:0] idx);
        logic [N-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign any_req    = |bus.req;
    assign owner_req  = bus.req[owner_q];
    assign other_req  = |(bus.req & ~onehot(owner_q));
    assign hold_limit = (hold_q == HOLD_LAST);

    // First requester at or above rr_ptr, wrapping past N-1 back to 0.
    always_comb begin
        logic found;
        int   idx;
        found  = 1'b0;
        winner = rr_ptr_q;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found && bus.req[idx]) begin
                winner = ID_W'(idx);
                found  = 1'b1;
            end
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; a missed default here would infer a latch.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        hold_d   = hold_q;
        turn_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                if (any_req) begin
                    state_d = GRANT;
                    grant_d = onehot(winner);
                    owner_d = winner;
                    hold_d  = '0;
                end
            end

            GRANT: begin
                if (!owner_req || (hold_limit && other_req)) begin
                    state_d  = TURN;
                    grant_d  = '0;
                    turn_d   = 1'b1;
                    rr_ptr_d = (owner_q == ID_W'(N - 1)) ? '0 : owner_q + 1'b1;
                end else if (hold_limit) begin
                    hold_d = '0;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end

            TURN: begin
                grant_d = '0;
                if (any_req) begin
                    state_d = GRANT;
                    grant_d = onehot(winner);
                    owner_d = winner;
                    hold_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            bus_en_q <= '0;
            busy_q   <= 1'b0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            hold_q   <= '0;
            turn_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            bus_en_q <= grant_d;
            busy_q   <= |grant_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            hold_q   <= hold_d;
            turn_q   <= turn_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.bus_en   = bus_en_q;
    assign bus.bus_busy = busy_q;
    assign bus.owner_id = owner_q;
    assign bus.turn     = turn_q;

    // Two enabled bufif1 drivers would short the bus.
    a_onehot_en: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus_en_q));
    a_en_matches_grant: assert property (@(posedge clk) disable iff (!rst_n)
        bus_en_q == grant_q);
endmodule
